// File: rtl/bus_master_ctrl.sv
// Master-side bus transaction sequencer: latches one core access, requests the bus, runs the strobe, returns data.
// Optional abort-on-timeout is built when BUS_TIMEOUT_EN is defined.
module bus_master_ctrl #(
    parameter int unsigned ADDR_W  = 30,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              reset_,
    input  logic              core_as_,
    input  logic              core_rw,
    input  logic [ADDR_W-1:0] core_addr,
    input  logic [DATA_W-1:0] core_wr_data,
    output logic [DATA_W-1:0] core_rd_data,
    output logic              core_busy,
    output logic              core_done,
    output logic              core_err,
    output logic              bus_req_,
    input  logic              bus_grnt_,
    output logic [ADDR_W-1:0] bus_addr,
    output logic              bus_as_,
    output logic              bus_rw,
    output logic [DATA_W-1:0] bus_wr_data,
    input  logic [DATA_W-1:0] bus_rd_data,
    input  logic              bus_rdy_
);

    if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_timeout_range
        $error("bus_master_ctrl: TIMEOUT must be within 1..255");
    end

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_ACCESS
    } state_e;

    state_e            st_q, st_d;
    logic              req_n_q, req_n_d;
    logic              as_n_q, as_n_d;
    logic              rw_q, rw_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

`ifdef BUS_TIMEOUT_EN
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

    logic       err_q, err_d;
    logic [7:0] tmo_q, tmo_d;
    logic       expired;

    assign expired = (tmo_q == TMO_LAST);
`endif

    always_comb begin
        st_d    = st_q;
        req_n_d = req_n_q;
        as_n_d  = as_n_q;
        rw_d    = rw_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
`ifdef BUS_TIMEOUT_EN
        err_d   = 1'b0;
        tmo_d   = tmo_q;
`endif
        unique case (st_q)
            ST_IDLE: begin
                // busy stays high through the done cycle and drops here unless a new access starts
                busy_d = 1'b0;
                if (!core_as_) begin
                    addr_d  = core_addr;
                    rw_d    = core_rw;
                    wdata_d = core_wr_data;
                    req_n_d = 1'b0;
                    busy_d  = 1'b1;
                    st_d    = ST_REQ;
`ifdef BUS_TIMEOUT_EN
                    tmo_d   = '0;
`endif
                end
            end
            ST_REQ: begin
`ifdef BUS_TIMEOUT_EN
                tmo_d = tmo_q + 8'd1;
`endif
                if (!bus_grnt_) begin
                    as_n_d = 1'b0;
                    st_d   = ST_ACCESS;
                end
`ifdef BUS_TIMEOUT_EN
                else if (expired) begin
                    req_n_d = 1'b1;
                    as_n_d  = 1'b1;
                    done_d  = 1'b1;
                    err_d   = 1'b1;
                    st_d    = ST_IDLE;
                end
`endif
            end
            ST_ACCESS: begin
`ifdef BUS_TIMEOUT_EN
                tmo_d = tmo_q + 8'd1;
`endif
                // ready on the expiry edge takes priority over the abort
                if (!bus_rdy_) begin
                    if (rw_q) begin
                        rdata_d = bus_rd_data;
                    end
                    done_d  = 1'b1;
                    req_n_d = 1'b1;
                    as_n_d  = 1'b1;
                    st_d    = ST_IDLE;
                end
`ifdef BUS_TIMEOUT_EN
                else if (expired) begin
                    req_n_d = 1'b1;
                    as_n_d  = 1'b1;
                    done_d  = 1'b1;
                    err_d   = 1'b1;
                    st_d    = ST_IDLE;
                end
`endif
            end
            default: begin
                st_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            st_q    <= ST_IDLE;
            req_n_q <= 1'b1;
            as_n_q  <= 1'b1;
            rw_q    <= 1'b1;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            st_q    <= st_d;
            req_n_q <= req_n_d;
            as_n_q  <= as_n_d;
            rw_q    <= rw_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

`ifdef BUS_TIMEOUT_EN
    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            err_q <= 1'b0;
            tmo_q <= '0;
        end else begin
            err_q <= err_d;
            tmo_q <= tmo_d;
        end
    end

    assign core_err = err_q;
`else
    assign core_err = 1'b0;
`endif

    assign core_rd_data = rdata_q;
    assign core_busy    = busy_q;
    assign core_done    = done_q;
    assign bus_req_     = req_n_q;
    assign bus_as_      = as_n_q;
    assign bus_rw       = rw_q;
    assign bus_addr     = addr_q;
    assign bus_wr_data  = wdata_q;

endmodule

// File: tb/tb_bus_master_ctrl.sv
// Randomized bench for bus_master_ctrl against a transaction-level timing model.
module tb_bus_master_ctrl;

    localparam int unsigned AW  = 30;
    localparam int unsigned DW  = 32;
    localparam int unsigned TMO = 16;

    logic          clk = 1'b0;
    logic          reset_ = 1'b0;
    logic          core_as_ = 1'b1;
    logic          core_rw = 1'b1;
    logic [AW-1:0] core_addr = '0;
    logic [DW-1:0] core_wr_data = '0;
    logic [DW-1:0] core_rd_data;
    logic          core_busy, core_done, core_err;
    logic          bus_req_;
    logic          bus_grnt_ = 1'b1;
    logic [AW-1:0] bus_addr;
    logic          bus_as_, bus_rw;
    logic [DW-1:0] bus_wr_data;
    logic [DW-1:0] bus_rd_data = '0;
    logic          bus_rdy_ = 1'b1;

    bus_master_ctrl #(
        .ADDR_W (AW),
        .DATA_W (DW),
        .TIMEOUT(TMO)
    ) dut (
        .clk         (clk),
        .reset_      (reset_),
        .core_as_    (core_as_),
        .core_rw     (core_rw),
        .core_addr   (core_addr),
        .core_wr_data(core_wr_data),
        .core_rd_data(core_rd_data),
        .core_busy   (core_busy),
        .core_done   (core_done),
        .core_err    (core_err),
        .bus_req_    (bus_req_),
        .bus_grnt_   (bus_grnt_),
        .bus_addr    (bus_addr),
        .bus_as_     (bus_as_),
        .bus_rw      (bus_rw),
        .bus_wr_data (bus_wr_data),
        .bus_rd_data (bus_rd_data),
        .bus_rdy_    (bus_rdy_)
    );

    always #5 clk = ~clk;

    int unsigned n_total = 0;
    int unsigned n_bad   = 0;

    // Reference state: what the bus side and core read port should be holding.
    logic [AW-1:0] m_addr = '0;
    logic          m_rw   = 1'b1;
    logic [DW-1:0] m_wd   = '0;
    logic [DW-1:0] m_rd   = '0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_bus_hold(input string tag);
        check({tag, ".addr"}, 64'(bus_addr), 64'(m_addr));
        check({tag, ".rw"}, 64'(bus_rw), 64'(m_rw));
        check({tag, ".wdata"}, 64'(bus_wr_data), 64'(m_wd));
    endtask

    task automatic check_idle(input string tag);
        check({tag, ".req"}, 64'(bus_req_), 64'(1'b1));
        check({tag, ".as"}, 64'(bus_as_), 64'(1'b1));
        check({tag, ".busy"}, 64'(core_busy), 64'(1'b0));
        check({tag, ".done"}, 64'(core_done), 64'(1'b0));
        check({tag, ".err"}, 64'(core_err), 64'(1'b0));
        check({tag, ".rdata"}, 64'(core_rd_data), 64'(m_rd));
        check_bus_hold(tag);
    endtask

    task automatic idle_cycle();
        core_as_ = 1'b1;
        @(negedge clk);
        check_idle("idle");
    endtask

    // One access: grant sampled g edges after the request edge's successor, then w wait states.
    // Returns at the negedge of the done cycle; caller decides whether core_as_ stays low.
    task automatic run_txn(input logic rw, input logic [AW-1:0] addr, input logic [DW-1:0] wd,
                           input logic [DW-1:0] rd, input int unsigned g, input int unsigned w);
        int unsigned t;
        bit          abort;
        abort = 1'b0;
        t     = g + w + 2;
`ifdef BUS_TIMEOUT_EN
        if (g + w + 1 > TMO - 1) begin
            abort = 1'b1;
            t     = TMO;
        end
`endif
        core_as_     = 1'b0;
        core_rw      = rw;
        core_addr    = addr;
        core_wr_data = wd;
        bus_grnt_    = 1'b1;
        bus_rdy_     = 1'b1;
        m_addr       = addr;
        m_rw         = rw;
        m_wd         = wd;
        for (int unsigned k = 0; k <= t; k++) begin
            @(negedge clk);
            if (k < t) begin
                check("act.req", 64'(bus_req_), 64'(1'b0));
                check("act.busy", 64'(core_busy), 64'(1'b1));
                check("act.done", 64'(core_done), 64'(1'b0));
                check("act.as", 64'(bus_as_), 64'((k >= g + 1) ? 1'b0 : 1'b1));
                check_bus_hold("act");
                core_as_     = 1'($urandom_range(0, 1));
                core_rw      = 1'($urandom_range(0, 1));
                core_addr    = AW'($urandom);
                core_wr_data = $urandom;
                if (k < g)       bus_grnt_ = 1'b1;
                else if (k == g) bus_grnt_ = 1'b0;
                else             bus_grnt_ = 1'($urandom_range(0, 1));
                if (k == g + 1 + w) begin
                    bus_rdy_    = 1'b0;
                    bus_rd_data = rd;
                end else begin
                    bus_rdy_    = (k <= g) ? 1'($urandom_range(0, 1)) : 1'b1;
                    bus_rd_data = $urandom;
                end
            end else begin
                if (!abort && rw) m_rd = rd;
                check("done.done", 64'(core_done), 64'(1'b1));
                check("done.err", 64'(core_err), 64'(abort));
                check("done.req", 64'(bus_req_), 64'(1'b1));
                check("done.as", 64'(bus_as_), 64'(1'b1));
                check("done.busy", 64'(core_busy), 64'(1'b1));
                check("done.rdata", 64'(core_rd_data), 64'(m_rd));
                check_bus_hold("done");
                core_as_  = 1'b1;
                bus_grnt_ = 1'b1;
                bus_rdy_  = 1'b1;
            end
        end
    endtask

    task automatic reset_mid_access();
        core_as_     = 1'b0;
        core_rw      = 1'b1;
        core_addr    = AW'($urandom);
        core_wr_data = $urandom;
        bus_grnt_    = 1'b1;
        bus_rdy_     = 1'b1;
        @(negedge clk);
        core_as_  = 1'b1;
        bus_grnt_ = 1'b0;
        @(negedge clk);
        check("rst.as_in_access", 64'(bus_as_), 64'(1'b0));
        @(negedge clk);
        #2 reset_ = 1'b0;
        #1;
        m_addr = '0;
        m_rw   = 1'b1;
        m_wd   = '0;
        m_rd   = '0;
        check_idle("rst.async");
        @(negedge clk);
        check_idle("rst.held");
        reset_    = 1'b1;
        bus_grnt_ = 1'b1;
        @(negedge clk);
        check_idle("rst.after");
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int unsigned g, w, gap;
        repeat (3) @(negedge clk);
        check_idle("reset");
        reset_ = 1'b1;
        idle_cycle();

        run_txn(1'b1, 30'h0000100, 32'h0, 32'hDEADBEEF, 1, 0);
        idle_cycle();
        run_txn(1'b0, 30'h0000200, 32'h12345678, 32'hCAFEF00D, 0, 3);
        idle_cycle();
        run_txn(1'b1, 30'h0000300, 32'h0, 32'hA5A5A5A5, 5, 1);
        idle_cycle();
        run_txn(1'b1, 30'h4, 32'h0, 32'h11112222, 1, 0);
        run_txn(1'b0, 30'h8, 32'h33334444, 32'h0, 1, 0);
        idle_cycle();

        reset_mid_access();
        run_txn(1'b1, 30'h0000040, 32'h0, 32'h5555AAAA, 1, 2);
        idle_cycle();

`ifdef BUS_TIMEOUT_EN
        run_txn(1'b1, 30'h0000500, 32'h0, 32'hBADBAD00, 0, 100);
        idle_cycle();
        run_txn(1'b1, 30'h0000504, 32'h0, 32'h600DF00D, 0, TMO - 2);
        idle_cycle();
`endif

        for (int i = 0; i < 150; i++) begin
`ifdef BUS_TIMEOUT_EN
            g = $urandom_range(0, 20);
            if (g == TMO - 1) g = TMO;
            w = $urandom_range(0, 20);
`else
            g = $urandom_range(0, 6);
            w = $urandom_range(0, 8);
`endif
            run_txn(1'($urandom_range(0, 1)), AW'($urandom), $urandom, $urandom, g, w);
            gap = $urandom_range(0, 2);
            repeat (gap) idle_cycle();
        end
        idle_cycle();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
